inv_round_sched: RTL and testbench

Gen2 inventory round scheduler implementing the Q-algorithm. It sequences the reader's command path: it decides per slot whether to issue Query, QueryRep or QueryAdjust, tracks slots and rounds, and adapts Q from slot outcomes (empty / single / collision). It sits above the command encoder/reader FSM. It receives one outcome per slot and hands out one command descriptor per slot over a valid/ready handshake.

---
 rtl/inv_round_sched.sv | 213 +++++++++++++++++++++
 tb/tb_inv_round_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round_sched.sv
// Gen2 inventory round scheduler: chooses Query / QueryRep / QueryAdjust per slot
// and adapts Q from slot outcomes using the Q-algorithm in eighths (qfp = Q*8).
module inv_round_sched #(
   parameter int Q_INIT     = 4,
   parameter int C_STEP     = 3,
   parameter int MAX_ROUNDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   output logic        cmd_vld,
   input  logic        cmd_rdy,
   output logic [1:0]  cmd_type,
   output logic [3:0]  cmd_q,
   output logic [2:0]  cmd_updn,
   input  logic        res_vld,
   input  logic [1:0]  res_code,
   output logic        busy,
   output logic        round_done,
   output logic        sess_done,
   output logic [15:0] tag_cnt
);

   // Handshake: a descriptor transfers on every rising edge where cmd_vld && cmd_rdy;
   // fields stay stable while cmd_vld is high and cmd_vld never drops without a transfer
   // except on stop.
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL} state_t;

   localparam logic [1:0] T_QUERY   = 2'd0;
   localparam logic [1:0] T_REP     = 2'd1;
   localparam logic [1:0] T_ADJ     = 2'd2;
   localparam logic [3:0] L_Q_INIT  = 4'(Q_INIT);
   localparam logic [6:0] L_QFP_INI = 7'(Q_INIT * 8);
   localparam logic [6:0] L_C_STEP  = 7'(C_STEP);
   localparam logic [7:0] L_MAX_RND = 8'(MAX_ROUNDS);

   state_t      r_state, w_state;
   logic [6:0]  r_qfp, w_qfp;
   logic [3:0]  r_q_cur, w_q_cur;
   logic [14:0] r_slot, w_slot;
   logic [7:0]  r_round, w_round;
   logic        r_hit, w_hit;
   logic [15:0] r_tag, w_tag;
   logic        r_cmd_vld, w_cmd_vld;
   logic [1:0]  r_cmd_type, w_cmd_type;
   logic [3:0]  r_cmd_q, w_cmd_q;
   logic [2:0]  r_cmd_updn, w_cmd_updn;
   logic        r_busy, w_busy;
   logic        r_round_done, w_round_done;
   logic        r_sess_done, w_sess_done;

   logic [7:0]  w_qfp_up;
   logic [6:0]  w_qfp_inc, w_qfp_dec;
   logic [4:0]  w_q_full;
   logic [3:0]  w_q_new;
   logic        w_slot_last;

   assign w_qfp_up    = {1'b0, r_qfp} + {1'b0, L_C_STEP};
   assign w_qfp_inc   = (w_qfp_up > 8'd120) ? 7'd120 : w_qfp_up[6:0];
   assign w_qfp_dec   = (r_qfp > L_C_STEP) ? (r_qfp - L_C_STEP) : 7'd0;
   // qfp never exceeds 120, so the +4 rounding cannot overflow 7 bits
   assign w_q_full    = 5'((r_qfp + 7'd4) >> 3);
   assign w_q_new     = (w_q_full > 5'd15) ? 4'd15 : w_q_full[3:0];
   assign w_slot_last = ({1'b0, r_slot} >= ((16'd1 << r_q_cur) - 16'd1));

   always_comb begin
      w_state      = r_state;
      w_qfp        = r_qfp;
      w_q_cur      = r_q_cur;
      w_slot       = r_slot;
      w_round      = r_round;
      w_hit        = r_hit;
      w_tag        = r_tag;
      w_cmd_vld    = r_cmd_vld;
      w_cmd_type   = r_cmd_type;
      w_cmd_q      = r_cmd_q;
      w_cmd_updn   = r_cmd_updn;
      w_busy       = r_busy;
      w_round_done = 1'b0;
      w_sess_done  = 1'b0;
      if (stop) begin
         w_state   = S_IDLE;
         w_cmd_vld = 1'b0;
         w_busy    = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_qfp      = L_QFP_INI;
                  w_q_cur    = L_Q_INIT;
                  w_tag      = 16'd0;
                  w_round    = 8'd0;
                  w_cmd_vld  = 1'b1;
                  w_cmd_type = T_QUERY;
                  w_cmd_q    = L_Q_INIT;
                  w_cmd_updn = 3'b000;
                  w_busy     = 1'b1;
                  w_state    = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_cmd_vld && cmd_rdy) begin
                  w_cmd_vld = 1'b0;
                  w_state   = S_WAIT;
                  if (r_cmd_type == T_REP) begin
                     w_slot = r_slot + 15'd1;
                  end else begin
                     w_slot  = 15'd0;
                     w_hit   = 1'b0;
                     w_round = r_round + 8'd1;
                     w_q_cur = r_cmd_q;
                  end
               end
            end
            S_WAIT: begin
               if (res_vld) begin
                  w_state = S_EVAL;
                  case (res_code)
                     2'd0: w_qfp = w_qfp_dec;
                     2'd1: begin
                        w_hit = 1'b1;
                        if (r_tag != 16'hFFFF) w_tag = r_tag + 16'd1;
                     end
                     default: begin
                        w_qfp = w_qfp_inc;
                        w_hit = 1'b1;
                     end
                  endcase
               end
            end
            S_EVAL: begin
               w_cmd_updn = 3'b000;
               w_cmd_q    = r_q_cur;
               if (w_q_new != r_q_cur) begin
                  w_round_done = 1'b1;
                  if (r_round == L_MAX_RND) begin
                     w_sess_done = 1'b1;
                     w_busy      = 1'b0;
                     w_state     = S_IDLE;
                  end else begin
                     w_cmd_vld  = 1'b1;
                     w_cmd_type = T_ADJ;
                     w_cmd_q    = w_q_new;
                     w_cmd_updn = (w_q_new > r_q_cur) ? 3'b110 : 3'b011;
                     w_state    = S_ISSUE;
                  end
               end else if (!w_slot_last) begin
                  w_cmd_vld  = 1'b1;
                  w_cmd_type = T_REP;
                  w_state    = S_ISSUE;
               end else begin
                  w_round_done = 1'b1;
                  if (r_hit && (r_round < L_MAX_RND)) begin
                     w_cmd_vld  = 1'b1;
                     w_cmd_type = T_QUERY;
                     w_state    = S_ISSUE;
                  end else begin
                     w_sess_done = 1'b1;
                     w_busy      = 1'b0;
                     w_state     = S_IDLE;
                  end
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_qfp        <= L_QFP_INI;
         r_q_cur      <= L_Q_INIT;
         r_slot       <= 15'd0;
         r_round      <= 8'd0;
         r_hit        <= 1'b0;
         r_tag        <= 16'd0;
         r_cmd_vld    <= 1'b0;
         r_cmd_type   <= T_QUERY;
         r_cmd_q      <= L_Q_INIT;
         r_cmd_updn   <= 3'b000;
         r_busy       <= 1'b0;
         r_round_done <= 1'b0;
         r_sess_done  <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_qfp        <= w_qfp;
         r_q_cur      <= w_q_cur;
         r_slot       <= w_slot;
         r_round      <= w_round;
         r_hit        <= w_hit;
         r_tag        <= w_tag;
         r_cmd_vld    <= w_cmd_vld;
         r_cmd_type   <= w_cmd_type;
         r_cmd_q      <= w_cmd_q;
         r_cmd_updn   <= w_cmd_updn;
         r_busy       <= w_busy;
         r_round_done <= w_round_done;
         r_sess_done  <= w_sess_done;
      end
   end

   assign cmd_vld    = r_cmd_vld;
   assign cmd_type   = r_cmd_type;
   assign cmd_q      = r_cmd_q;
   assign cmd_updn   = r_cmd_updn;
   assign busy       = r_busy;
   assign round_done = r_round_done;
   assign sess_done  = r_sess_done;
   assign tag_cnt    = r_tag;

endmodule

// File: tb/tb_inv_round_sched.sv
// Bench for inv_round_sched: four instances with different Q_INIT / MAX_ROUNDS share
// one stimulus; each test follows one instance and returns all of them to IDLE with stop.
module tb_inv_round_sched;

   localparam logic [3:0][7:0] QI = {8'd4, 8'd1, 8'd0, 8'd4};
   localparam logic [3:0][7:0] MR = {8'd1, 8'd64, 8'd64, 8'd64};
   localparam int CS = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, stop = 1'b0, cmd_rdy = 1'b1, res_vld = 1'b0;
   logic [1:0] res_code = 2'd0;

   logic [3:0]       vld_a, busy_a, rd_a, sd_a;
   logic [3:0][1:0]  type_a;
   logic [3:0][3:0]  q_a;
   logic [3:0][2:0]  updn_a;
   logic [3:0][15:0] tag_a;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      inv_round_sched #(
         .Q_INIT(int'(QI[g])), .C_STEP(CS), .MAX_ROUNDS(int'(MR[g]))
      ) u_dut (
         .clk(clk), .rst(rst), .start(start), .stop(stop),
         .cmd_vld(vld_a[g]), .cmd_rdy(cmd_rdy), .cmd_type(type_a[g]),
         .cmd_q(q_a[g]), .cmd_updn(updn_a[g]), .res_vld(res_vld),
         .res_code(res_code), .busy(busy_a[g]), .round_done(rd_a[g]),
         .sess_done(sd_a[g]), .tag_cnt(tag_a[g])
      );
   end

   typedef struct {
      logic [1:0] code;
      int         e_type;
      int         e_q;
      int         e_updn;
      int         e_rd;
   } vec_t;
   vec_t tbl[9];

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic check_out(input int g, input string nm, input int e_vld, input int e_type,
                            input int e_q, input int e_updn, input int e_rd, input int e_sd,
                            input int e_busy);
      chk({nm, ".vld"}, int'(vld_a[g]), e_vld);
      if (e_vld == 1) begin
         chk({nm, ".type"}, int'(type_a[g]), e_type);
         chk({nm, ".q"}, int'(q_a[g]), e_q);
         chk({nm, ".updn"}, int'(updn_a[g]), e_updn);
      end
      chk({nm, ".round_done"}, int'(rd_a[g]), e_rd);
      chk({nm, ".sess_done"}, int'(sd_a[g]), e_sd);
      chk({nm, ".busy"}, int'(busy_a[g]), e_busy);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   // Transfer the pending descriptor, deliver one outcome, land on the next descriptor.
   task automatic do_slot(input logic [1:0] code);
      tick();
      res_vld  = 1'b1;
      res_code = code;
      tick();
      res_vld = 1'b0;
      tick();
   endtask

   // Transaction-level reference: one session of random outcomes and handshake stalls.
   task automatic rand_sess(input int g, input int max_slots);
      int qfp, q, slot, rounds, tag, qn, d_type, d_q, d_updn, k, r;
      bit hit, ended, rd;
      logic [1:0] code;
      qfp = int'(QI[g]) * 8; q = int'(QI[g]); slot = 0; rounds = 0; tag = 0; hit = 0;
      d_type = 0; d_q = int'(QI[g]); d_updn = 0; ended = 0;
      do_start();
      check_out(g, "rnd.start", 1, 0, d_q, 0, 0, 0, 1);
      for (int s = 0; s < max_slots && !ended; s++) begin
         k = $urandom_range(0, 2);
         cmd_rdy = 1'b0;
         for (int i = 0; i < k; i++) begin
            res_vld = 1'($urandom_range(0, 1));
            tick();
            check_out(g, "rnd.stall", 1, d_type, d_q, d_updn, 0, 0, 1);
         end
         res_vld = 1'b0;
         cmd_rdy = 1'b1;
         tick();
         if (d_type == 1) slot++;
         else begin slot = 0; hit = 0; rounds++; q = d_q; end
         repeat ($urandom_range(0, 1)) tick();
         r = $urandom_range(0, 9);
         code = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         res_vld = 1'b1; res_code = code;
         tick();
         res_vld = 1'b0;
         tick();
         if (code == 2'd0) qfp = (qfp > CS) ? qfp - CS : 0;
         else if (code == 2'd1) begin hit = 1; if (tag < 65535) tag++; end
         else begin hit = 1; qfp = (qfp + CS > 120) ? 120 : qfp + CS; end
         qn = (qfp + 4) / 8;
         if (qn > 15) qn = 15;
         rd = 1;
         if (qn != q) begin
            if (rounds == int'(MR[g])) ended = 1;
            else begin d_type = 2; d_q = qn; d_updn = (qn > q) ? 6 : 3; end
         end else if (slot < (1 << q) - 1) begin
            rd = 0; d_type = 1; d_q = q; d_updn = 0;
         end else if (hit && rounds < int'(MR[g])) begin
            d_type = 0; d_q = q; d_updn = 0;
         end else ended = 1;
         if (ended) check_out(g, "rnd.end", 0, 0, 0, 0, 1, 1, 0);
         else check_out(g, "rnd.cmd", 1, d_type, d_q, d_updn, int'(rd), 0, 1);
         chk("rnd.tag", int'(tag_a[g]), tag);
      end
      do_stop();
   endtask

   initial begin
      tbl[0] = '{2'd2, 1, 4, 0, 0};
      tbl[1] = '{2'd2, 2, 5, 6, 1};
      tbl[2] = '{2'd0, 2, 4, 3, 1};
      tbl[3] = '{2'd1, 1, 4, 0, 0};
      tbl[4] = '{2'd0, 1, 4, 0, 0};
      tbl[5] = '{2'd0, 1, 4, 0, 0};
      tbl[6] = '{2'd0, 2, 3, 3, 1};
      tbl[7] = '{2'd1, 1, 3, 0, 0};
      tbl[8] = '{2'd2, 2, 4, 6, 1};

      // Reset values
      repeat (3) tick();
      check_out(0, "reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset.type", int'(type_a[0]), 0);
      chk("reset.q", int'(q_a[0]), 4);
      chk("reset.q0", int'(q_a[1]), 0);
      chk("reset.updn", int'(updn_a[0]), 0);
      chk("reset.tag", int'(tag_a[0]), 0);
      rst = 1'b1;
      tick();

      // Table-driven slot sequence from Q=4; MAX_ROUNDS=1 instance ends at first close
      do_start();
      check_out(0, "start", 1, 0, 4, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         do_slot(tbl[i].code);
         check_out(0, $sformatf("tbl%0d", i), 1, tbl[i].e_type, tbl[i].e_q,
                   tbl[i].e_updn, tbl[i].e_rd, 0, 1);
         if (i == 1) check_out(3, "mr1.end", 0, 0, 0, 0, 1, 1, 0);
      end
      chk("tbl.tag", int'(tag_a[0]), 2);
      do_stop();
      check_out(0, "tbl.stop", 0, 0, 0, 0, 0, 0, 0);

      // Q_INIT=0: one empty closes round and session together
      do_start();
      check_out(1, "q0.start", 1, 0, 0, 0, 0, 0, 1);
      do_slot(2'd0);
      check_out(1, "q0.end", 0, 0, 0, 0, 1, 1, 0);
      chk("q0.tag", int'(tag_a[1]), 0);
      repeat (3) tick();
      check_out(1, "q0.idle", 0, 0, 0, 0, 0, 0, 0);
      do_stop();

      // Q_INIT=1: single, single, then empties until the session ends
      do_start();
      check_out(2, "q1.start", 1, 0, 1, 0, 0, 0, 1);
      do_slot(2'd1);
      check_out(2, "q1.s1", 1, 1, 1, 0, 0, 0, 1);
      do_slot(2'd1);
      check_out(2, "q1.s2", 1, 0, 1, 0, 1, 0, 1);
      chk("q1.tag", int'(tag_a[2]), 2);
      do_slot(2'd0);
      check_out(2, "q1.e1", 1, 1, 1, 0, 0, 0, 1);
      do_slot(2'd0);
      check_out(2, "q1.e2", 1, 2, 0, 3, 1, 0, 1);
      do_slot(2'd0);
      check_out(2, "q1.e3", 0, 0, 0, 0, 1, 1, 0);
      chk("q1.tag_kept", int'(tag_a[2]), 2);
      do_stop();

      // Stalled handshake: descriptor held, results ignored; stop mid-handshake
      cmd_rdy = 1'b0;
      do_start();
      for (int i = 0; i < 5; i++) begin
         res_vld = 1'(i % 2 == 0);
         res_code = 2'd2;
         tick();
         check_out(0, $sformatf("stall%0d", i), 1, 0, 4, 0, 0, 0, 1);
      end
      res_vld = 1'b0;
      do_stop();
      check_out(0, "stall.stop", 0, 0, 0, 0, 0, 0, 0);
      cmd_rdy = 1'b1;

      // start and stop together: stop wins
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check_out(0, "startstop", 0, 0, 0, 0, 0, 0, 0);
      tick();
      check_out(0, "startstop2", 0, 0, 0, 0, 0, 0, 0);

      // Random sessions against the reference model
      for (int g = 0; g < 4; g++) begin
         rand_sess(g, 120);
         rand_sess(g, 120);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
